// File: rtl/mac_psum_collector.sv
// Consumer side of the 8-lane MAC: tracks the fixed MAC latency, accumulates
// partial sums into dot products (optional ReLU) and buffers results in a FWFT FIFO.
module mac_psum_collector #(
    parameter int bw_psum    = 22,
    parameter int acc_bw     = 30,
    parameter int MAC_LAT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic                      relu_en,
    output logic                      in_ready,
    input  logic signed [bw_psum-1:0] mac_out,
    output logic [acc_bw-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IF_W  = $clog2(MAC_LAT + 1);

    // Valid/ready: a beat issues on in_valid & in_ready; a result pops on out_valid & out_ready.
    logic [MAC_LAT-1:0] stage_valid, stage_last, stage_relu;
    logic               issue;
    logic               consume_valid, consume_last, consume_relu;

    logic signed [acc_bw-1:0] acc, mac_ext, sum, result;
    logic                     first;

    logic [acc_bw-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [IF_W-1:0]   inflight;
    logic              push, pop;

    assign issue         = in_valid & in_ready;
    assign consume_valid = stage_valid[MAC_LAT-1];
    assign consume_last  = stage_last[MAC_LAT-1];
    assign consume_relu  = stage_relu[MAC_LAT-1];

    // Delay line mirrors the MAC pipeline so each mac_out is matched to its beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= '0;
            stage_last  <= '0;
            stage_relu  <= '0;
        end else begin
            stage_valid[0] <= issue;
            stage_last[0]  <= in_last;
            stage_relu[0]  <= relu_en;
            for (int i = 1; i < MAC_LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_last[i]  <= stage_last[i-1];
                stage_relu[i]  <= stage_relu[i-1];
            end
        end
    end

    always_comb begin
        mac_ext = acc_bw'(mac_out);
        sum     = (first ? '0 : acc) + mac_ext;
        result  = (consume_relu && sum[acc_bw-1]) ? '0 : sum;
    end

    assign push = consume_valid & consume_last;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            first <= 1'b1;
        end else if (consume_valid) begin
            acc   <= sum;
            first <= consume_last;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Credit counts results already buffered plus dot products that will close in flight.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MAC_LAT; i++) begin
            inflight = inflight + IF_W'(stage_valid[i] & stage_last[i]);
        end
    end

    assign in_ready  = (32'(count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = (|stage_valid) | ~first;

endmodule

// File: tb/tb_mac_psum_collector.sv
// Directed bench for mac_psum_collector with a MAC latency model and result scoreboard.
module tb_mac_psum_collector;
    localparam int BW   = 22;
    localparam int AW   = 30;
    localparam int LAT  = 4;
    localparam int DEP  = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid, in_last, relu_en, in_ready;
    logic signed [BW-1:0] mac_out;
    logic [AW-1:0]        out_data;
    logic                 out_valid, out_ready, busy;

    logic signed [BW-1:0] cur_val;
    logic signed [BW-1:0] pipe [LAT];
    logic [AW-1:0]        exp_q[$];

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int stalls = 0;

    typedef struct {
        int n;
        int v0;
        int v1;
        int v2;
        bit relu;
        int exp;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    mac_psum_collector #(
        .bw_psum(BW), .acc_bw(AW), .MAC_LAT(LAT), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .relu_en(relu_en), .in_ready(in_ready), .mac_out(mac_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    // MAC model: returns the issued operand's value LAT edges later, junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= (in_valid && in_ready) ? cur_val : 22'sh2AAAA;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_out = pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshake must deliver the oldest expected result.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no result", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end else if (!out_valid) begin
                check("empty_data_zero", 32'(out_data), 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && dut.push) begin
            checks++;
            if (int'(dut.count) >= DEP) begin
                errors++;
                $display("FAIL push_while_full: count %0d depth %0d", dut.count, DEP);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int val, input bit last, input bit relu);
        int n;
        cur_val  = BW'(val);
        in_last  = last;
        relu_en  = relu;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        check("issue_credit", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        relu_en  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int p0;
        int vv[3];

        tbl[0] = '{1, 5, 0, 0, 1'b0, 5};
        tbl[1] = '{3, 100, -50, 7, 1'b0, 57};
        tbl[2] = '{2, -10, -20, 0, 1'b1, 0};
        tbl[3] = '{2, -10, -20, 0, 1'b0, -30};
        tbl[4] = '{1, -7, 0, 0, 1'b1, 0};
        tbl[5] = '{1, -7, 0, 0, 1'b0, -7};
        tbl[6] = '{2, 2097151, 2097151, 0, 1'b1, 4194302};
        tbl[7] = '{2, -2097152, -2097152, 0, 1'b0, -4194304};
        tbl[8] = '{3, 40, -100, 55, 1'b1, 0};

        // Reset held 3 cycles with random inputs
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; relu_en = 1'b0; out_ready = 1'b0; cur_val = '0;
        repeat (3) begin
            step();
            in_valid  = 1'($urandom_range(0, 1));
            in_last   = 1'($urandom_range(0, 1));
            relu_en   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cur_val   = BW'($urandom);
        end
        step();
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        step();

        // Table-driven dot products
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(AW'(tbl[i].exp));
            vv[0] = tbl[i].v0; vv[1] = tbl[i].v1; vv[2] = tbl[i].v2;
            for (int b = 0; b < tbl[i].n; b++) begin
                issue(vv[b], b == tbl[i].n - 1, tbl[i].relu);
            end
            drain("vec_drain");
        end

        // Multi-beat latency and busy window
        exp_q.push_back(AW'(57));
        issue(100, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_after_first", 32'(busy), 32'd1);
        step();
        issue(-50, 1'b0, 1'b0);
        issue(7, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("ov_latency", 32'(out_valid), 32'(k == 5));
            check("busy_window", 32'(busy), 32'(k < 5));
        end
        step();
        drain("lat_drain");

        // Backpressure: only DEP credits with out_ready low
        out_ready = 1'b0;
        accepted  = 0;
        cur_val   = BW'(200);
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(AW'(200 + accepted));
                accepted++;
            end
            step();
            cur_val = BW'(200 + accepted);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_accepted", 32'(accepted), 32'(DEP));
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'd200);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(AW'(208 + i));
            issue(208 + i, 1'b1, 1'b0);
        end
        drain("bp_drain");

        // Back-to-back single-beat products with pops
        stalls = 0;
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(AW'(i * 37 - 300));
            issue(i * 37 - 300, 1'b1, 1'b0);
        end
        repeat (6) @(negedge clk);
        check("b2b_pops", 32'(pops - p0), 32'd20);
        check("b2b_no_stall", 32'(stalls), 32'd0);
        step();
        drain("b2b_drain");

        // Reset mid-accumulation discards the open dot product
        issue(1000, 1'b0, 1'b0);
        issue(2000, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        p0 = pops;
        exp_q.push_back(AW'(3));
        issue(3, 1'b1, 1'b0);
        drain("rst_mid_drain");
        repeat (6) step();
        check("rst_mid_pops", 32'(pops - p0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_psum_collector.md
# mac_psum_collector

Consumer side of the 8-lane MAC datapath: tracks the fixed pipeline latency of the MAC, which has no valid signal. Accumulates its per-beat partial sums into complete dot products, with optional ReLU. Buffers results in a small FIFO behind a valid/ready output. Issues credit-based `in_ready` to the upstream sequencer because the MAC pipeline cannot stall.

## Interface
Parameters:
- `bw_psum`, 22: width of the MAC partial-sum output (signed).
- `acc_bw`, 30: accumulator and result width (signed).
- `MAC_LAT`, 4: clock edges from the MAC input sample to this block's capture of the matching `mac_out`.
- `FIFO_DEPTH`, 8: result FIFO entries, a power of 2, ≥ 2.

Ports:
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `in_valid` input, 1: the sequencer presents a beat to the MAC this cycle.
- `in_last` input, 1: this beat is the final chunk of a dot product.
- `relu_en` input, 1: apply ReLU to the dot product closed by this beat. Meaningful only with `in_last`.
- `in_ready` output, 1: credit available. A beat issues only on `in_valid & in_ready`.
- `mac_out` input, `bw_psum`: signed partial sum from the MAC.
- `out_data` output, `acc_bw`: FIFO head result.
- `out_valid` output, 1: FIFO not empty.
- `out_ready` input, 1: downstream accepts the head.
- `busy` output, 1: a beat is in flight or a partial accumulation is open.

## Operation
- Issue = `in_valid & in_ready` at edge t. The sequencer drives the MAC `a`/`b` inputs only on issue cycles. Non-issue MAC outputs are ignored.
- Delay line: `MAC_LAT` stages, each holding {valid, last, relu}.
  - Issue at edge t enters stage 1 at edge t.
  - It reaches stage `MAC_LAT` at edge t+`MAC_LAT`-1.
  - It is consumed at edge t+`MAC_LAT`, together with `mac_out`.
- Accumulate on a consumed valid beat:
  - `sum = (first ? 0 : acc) + sext(mac_out)`, width `acc_bw`.
  - Two's-complement wrap on overflow, no saturation.
- If the beat is not last: `acc <= sum`, `first <= 0`.
- If the beat is last:
  - Push `relu ? (sum<0 ? 0 : sum) : sum` into the FIFO.
  - Set `first <= 1`. `acc` is then don't-care.
- A single-beat dot product (first and last together) yields `sext(mac_out)`, optionally ReLU'd.
- FIFO is first-word fall-through:
  - `out_valid = count != 0`; `out_data` = head.
  - `out_data` is 0 when empty.
  - Pop on `out_valid & out_ready`.
  - Push and pop at the same edge: count unchanged, order preserved.
- Credit rule:
  - `inflight` = number of stages with valid & last.
  - `in_ready = (count + inflight) < FIFO_DEPTH`, computed from registers only (no combinational path from `in_valid` or `out_ready`).
  - Consequently a push never meets a full FIFO. The verification bench asserts this.
- `in_ready` gates all beats, including non-last ones. The sequencer holds its MAC operands while stalled.
- `busy = |stage_valid | !first`.
- Reset: clears the delay line, `first=1`, `acc=0`, FIFO `count=0`, pointers 0.
  - Outputs after reset: `out_valid=0`, `out_data=0`, `in_ready=1`, `busy=0`.
  - Reset mid-operation discards in-flight beats, the open accumulation and buffered results. Stale MAC pipeline contents are ignored because the delay line is cleared.

## Timing
- Last beat issued at edge t → FIFO push at edge t+`MAC_LAT` → `out_valid` high in the cycle after edge t+`MAC_LAT`.
- Minimum issue-to-`out_valid` latency is 5 cycles at default parameters.
- Throughput: 1 beat/cycle.
  - Single-beat dot products with `out_ready=1` sustain 1 result/cycle without deasserting `in_ready`: `count ≤ 1`, `inflight ≤ 4`, total < 8.
- `in_ready` reflects state after the previous edge: a pop at edge e frees credit in the cycle after e.
- `relu_en` is sampled only at issue. Changes while a beat is in flight have no effect.

## Test plan
- **Reset:** hold `reset` 3 cycles with random inputs → `out_valid=0`, `out_data=0`, `in_ready=1`, `busy=0`. Then issue a single-beat dot product with `mac_out=5` → `out_data=5`.
- **Multi-beat:** issue 3 beats (last on the 3rd), MAC model returns 100, −50, 7 → `out_data=57`, `out_valid` rises 5 cycles after the 3rd issue. `busy` is high from the 1st issue until the push.
- **ReLU:** two 2-beat dot products returning −10, −20, first with `relu_en=1`, then `relu_en=0` → results 0, then −30 (sign-extended to 30 bits).
- **Backpressure:** `out_ready=0`, request 10 single-beat last issues every cycle →
  - exactly 8 accepted, then `in_ready=0`;
  - raise `out_ready` → 8 results in issue order, then the remaining 2 issue and complete;
  - no push-while-full assertion fires.
- **Back-to-back with pops:** 20 single-beat dot products with distinct values and `out_ready=1` → one result per cycle, `in_ready` never drops, all values match.
- **Reset mid-operation:** issue 2 non-last beats (mac_out 1000, 2000), assert reset 1 cycle, then a 1-beat last with mac_out 3 → single result 3, no other output.
